// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM access arbiter: command encodings, FSM states, payload layout.
package ram_arb_pkg;

    localparam int unsigned WORD_W          = 10;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        cmd_e              cmd;
        logic [DATA_W-1:0] payload;
    } cmd_word_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester, response and RAM-side signals of the arbiter.
interface ram_access_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [WORD_W-1:0] req0_data;
    logic [WORD_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp0_data;
    logic [DATA_W-1:0] rsp1_data;
    logic [WORD_W-1:0] ram_din;
    logic              ram_rx_valid;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_tx_valid;
    logic              grant_id;
    logic              busy;
    logic              err;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, ram_dout, ram_tx_valid,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
               ram_din, ram_rx_valid, grant_id, busy, err
    );

    // Requesters and RAM side
    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, ram_dout, ram_tx_valid,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
               ram_din, ram_rx_valid, grant_id, busy, err
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// Saturating idle-cycle counter; flags the TIMEOUT-th consecutive enabled cycle.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, holding at TIMEOUT instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Current cycle is the TIMEOUT-th enabled one
    assign o_expired_c = i_enable && (r_count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-port arbiter onto a single-port RAM with address locking and read-wait timeout.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    ram_access_arbiter_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_owner;
    logic              r_last;
    logic              r_busy;
    logic              r_err;
    logic [WORD_W-1:0] r_ram_din;
    logic              r_ram_rx_valid;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_data;
    logic [DATA_W-1:0] r_rsp1_data;

    logic              w_ready0;
    logic              w_ready1;
    logic              w_ready0_g;
    logic              w_ready1_g;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    cmd_word_t         w_acc_word;
    logic              w_owner_valid;
    logic              w_tmr_en;
    logic              w_tmr_clear;
    logic              w_expired;
    logic              w_err_nxt;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_rsp_data;

    // Ready generation: round-robin tie-break in IDLE, owner-only while LOCKED
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_ready0 = r_last;
                    w_ready1 = !r_last;
                end else begin
                    w_ready0 = bus.req0_valid;
                    w_ready1 = bus.req1_valid;
                end
            end
            LOCKED: begin
                w_ready0 = !r_owner;
                w_ready1 = r_owner;
            end
            default: begin
                w_ready0 = 1'b0;
                w_ready1 = 1'b0;
            end
        endcase
    end

    // Ready is held low while reset is asserted
    assign w_ready0_g     = w_ready0 & rst_n;
    assign w_ready1_g     = w_ready1 & rst_n;
    assign w_acc0         = w_ready0_g & bus.req0_valid;
    assign w_acc1         = w_ready1_g & bus.req1_valid;
    assign w_acc          = w_acc0 | w_acc1;
    assign w_acc_word     = w_acc1 ? cmd_word_t'(bus.req1_data) : cmd_word_t'(bus.req0_data);
    assign w_owner_valid  = r_owner ? bus.req1_valid : bus.req0_valid;

    // Timer runs while the lock owner is silent or the RAM has not answered
    assign w_tmr_en    = ((r_state == LOCKED)  && !w_owner_valid) ||
                         ((r_state == RD_WAIT) && !bus.ram_tx_valid);
    assign w_tmr_clear = w_acc | w_rsp_fire | (w_state_nxt != r_state);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_tmr_clear),
        .i_enable    (w_tmr_en),
        .o_expired_c (w_expired)
    );

    // Next-state, response and error decode
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_rsp_fire  = 1'b0;
        w_rsp_data  = '0;
        unique case (r_state)
            IDLE, LOCKED: begin
                if (w_acc) begin
                    unique case (w_acc_word.cmd)
                        CMD_WR_ADDR, CMD_RD_ADDR: w_state_nxt = LOCKED;
                        CMD_WR_DATA:              w_state_nxt = IDLE;
                        CMD_RD_DATA:              w_state_nxt = RD_WAIT;
                        default:                  w_state_nxt = IDLE;
                    endcase
                end else if ((r_state == LOCKED) && w_expired) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (bus.ram_tx_valid) begin
                    w_state_nxt = IDLE;
                    w_rsp_fire  = 1'b1;
                    w_rsp_data  = bus.ram_dout;
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_rsp_fire  = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, ownership and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner        <= 1'b0;
            r_last         <= 1'b1;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_rsp0_valid   <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_rsp0_data    <= '0;
            r_rsp1_data    <= '0;
        end else begin
            r_ram_rx_valid <= w_acc;
            r_busy         <= (w_state_nxt != IDLE);
            r_err          <= w_err_nxt;
            r_rsp0_valid   <= w_rsp_fire && !r_owner;
            r_rsp1_valid   <= w_rsp_fire && r_owner;
            if (w_acc) begin
                r_ram_din <= WORD_W'(w_acc_word);
                r_owner   <= w_acc1;
                r_last    <= w_acc1;
            end
            if (w_rsp_fire) begin
                if (r_owner) begin
                    r_rsp1_data <= w_rsp_data;
                end else begin
                    r_rsp0_data <= w_rsp_data;
                end
            end
        end
    end

    assign bus.req0_ready   = w_ready0_g;
    assign bus.req1_ready   = w_ready1_g;
    assign bus.ram_din      = r_ram_din;
    assign bus.ram_rx_valid = r_ram_rx_valid;
    assign bus.rsp0_valid   = r_rsp0_valid;
    assign bus.rsp1_valid   = r_rsp1_valid;
    assign bus.rsp0_data    = r_rsp0_data;
    assign bus.rsp1_data    = r_rsp1_data;
    assign bus.grant_id     = r_owner;
    assign bus.busy         = r_busy;
    assign bus.err          = r_err;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: directed traffic, monitor checks RAM strobes, responses, errors.
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_access_arbiter_if bus();

    ram_access_arbiter #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    logic [9:0] q_ram[$];
    logic [7:0] q_rsp0[$];
    logic [7:0] q_rsp1[$];
    logic [9:0] m_word;
    logic [7:0] m_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ram_rx_valid"}, 32'(bus.ram_rx_valid), 0);
        check({tag, " ram_din"},      32'(bus.ram_din), 0);
        check({tag, " rsp0_valid"},   32'(bus.rsp0_valid), 0);
        check({tag, " rsp1_valid"},   32'(bus.rsp1_valid), 0);
        check({tag, " rsp0_data"},    32'(bus.rsp0_data), 0);
        check({tag, " rsp1_data"},    32'(bus.rsp1_data), 0);
        check({tag, " grant_id"},     32'(bus.grant_id), 0);
        check({tag, " busy"},         32'(bus.busy), 0);
        check({tag, " err"},          32'(bus.err), 0);
        check({tag, " req0_ready"},   32'(bus.req0_ready), 0);
        check({tag, " req1_ready"},   32'(bus.req1_ready), 0);
    endtask

    // Present one word on a port until accepted (bounded), then drop valid
    task automatic send(input int port, input logic [9:0] w);
        int   k;
        logic rdy;
        @(posedge clk); #1;
        if (port == 0) begin bus.req0_valid = 1'b1; bus.req0_data = w; end
        else           begin bus.req1_valid = 1'b1; bus.req1_data = w; end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
        end while (!rdy && k < 50);
        check($sformatf("send p%0d %03h accepted", port, w), 32'(rdy), 1);
        if (rdy) q_ram.push_back(w);
        @(posedge clk); #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe
    always @(negedge clk) begin
        if (bus.ram_rx_valid === 1'b1) begin
            n_tests++;
            if (q_ram.size() == 0) begin
                n_fail++;
                $display("FAIL ram_rx_valid: unexpected strobe with %03h, none required", bus.ram_din);
            end else begin
                m_word = q_ram.pop_front();
                n_tests--;
                check("ram_din", 32'(bus.ram_din), 32'(m_word));
            end
        end
        if (bus.rsp0_valid === 1'b1) begin
            n_tests++;
            if (q_rsp0.size() == 0) begin
                n_fail++;
                $display("FAIL rsp0_valid: unexpected pulse with %02h, none required", bus.rsp0_data);
            end else begin
                m_byte = q_rsp0.pop_front();
                n_tests--;
                check("rsp0_data", 32'(bus.rsp0_data), 32'(m_byte));
            end
        end
        if (bus.rsp1_valid === 1'b1) begin
            n_tests++;
            if (q_rsp1.size() == 0) begin
                n_fail++;
                $display("FAIL rsp1_valid: unexpected pulse with %02h, none required", bus.rsp1_data);
            end else begin
                m_byte = q_rsp1.pop_front();
                n_tests--;
                check("rsp1_data", 32'(bus.rsp1_data), 32'(m_byte));
            end
        end
        if (bus.err === 1'b1) begin
            n_tests++;
            if (exp_err == 0) begin
                n_fail++;
                $display("FAIL err: unexpected pulse, got 1 required 0");
            end else begin
                exp_err--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n            = 1'b0;
        bus.req0_valid   = 1'b1;
        bus.req1_valid   = 1'b1;
        bus.req0_data    = 10'h012;
        bus.req1_data    = 10'h034;
        bus.ram_dout     = 8'h00;
        bus.ram_tx_valid = 1'b0;

        // Reset state, ready held low even with valid inputs
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // First tie after reset goes to port 0; its address locks the arbiter
        rst_n = 1'b1;
        #1;
        check("tie0 req0_ready", 32'(bus.req0_ready), 1);
        check("tie0 req1_ready", 32'(bus.req1_ready), 0);
        q_ram.push_back(10'h012);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lock0 busy", 32'(bus.busy), 1);
        check("lock0 grant_id", 32'(bus.grant_id), 0);
        check("lock0 req1_ready", 32'(bus.req1_ready), 0);

        // Locked read: new address supersedes, then read-data waits for RAM
        send(0, 10'h2A5);
        send(0, 10'h300);
        @(negedge clk);
        check("rdwait busy", 32'(bus.busy), 1);
        check("rdwait req0_ready", 32'(bus.req0_ready), 0);
        check("rdwait req1_ready", 32'(bus.req1_ready), 0);
        @(posedge clk);
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'h5C;
        q_rsp0.push_back(8'h5C);
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        @(negedge clk);
        check("after rsp busy", 32'(bus.busy), 0);
        check("pending p1 req1_ready", 32'(bus.req1_ready), 1);
        q_ram.push_back(10'h034);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("lock1 grant_id", 32'(bus.grant_id), 1);
        check("lock1 busy", 32'(bus.busy), 1);

        // Port 1 address update then write data releases the lock
        send(1, 10'h010);
        send(1, 10'h1FF);
        @(negedge clk);
        check("release busy", 32'(bus.busy), 0);

        // Tie after port 1 was granted goes to port 0; single-word writes take no lock
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 10'h1AA;
        bus.req1_valid = 1'b1; bus.req1_data = 10'h155;
        @(negedge clk);
        check("tie1 req0_ready", 32'(bus.req0_ready), 1);
        check("tie1 req1_ready", 32'(bus.req1_ready), 0);
        q_ram.push_back(10'h1AA);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("single-word busy", 32'(bus.busy), 0);
        check("loser next req1_ready", 32'(bus.req1_ready), 1);
        q_ram.push_back(10'h155);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;

        // Lock timeout: owner silent for 15 cycles releases to waiting port 1
        send(0, 10'h007);
        bus.req1_valid = 1'b1; bus.req1_data = 10'h1C3;
        exp_err++;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.req1_ready && k < 40);
        check("lock timeout cycle", 32'(k), 16);
        check("lock timeout busy", 32'(bus.busy), 0);
        if (bus.req1_ready) q_ram.push_back(10'h1C3);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;

        // Normal read from IDLE on port 1
        send(1, 10'h3EE);
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'hA7;
        q_rsp1.push_back(8'hA7);
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        @(negedge clk);
        check("read1 busy", 32'(bus.busy), 0);
        check("read1 rsp1_data held", 32'(bus.rsp1_data), 32'h0A7);

        // Read timeout: zero data response plus err, late RAM data ignored
        send(1, 10'h3EE);
        q_rsp1.push_back(8'h00);
        exp_err++;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < 40);
        check("read timeout cycle", 32'(k), 16);
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'hFF;
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("late tx rsp1_data", 32'(bus.rsp1_data), 0);
        check("late tx busy", 32'(bus.busy), 0);

        // Reset during a pending read discards it
        send(0, 10'h300);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-read reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'h77;
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("post-reset busy", 32'(bus.busy), 0);
        check("post-reset rsp0_data", 32'(bus.rsp0_data), 0);

        // Every expectation consumed
        check("ram queue drained", 32'(q_ram.size()), 0);
        check("rsp0 queue drained", 32'(q_rsp0.size()), 0);
        check("rsp1 queue drained", 32'(q_rsp1.size()), 0);
        check("err pulses outstanding", 32'(exp_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: idle/wait cycles before a held lock or read wait is abandoned.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1  requester N presents a 10-bit RAM command word.
REQ-005 req0_data, req1_data  input  10  command word; [9:8] = 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-006 req0_ready, req1_ready  output  1  word accepted when valid && ready in the same cycle.
REQ-007 rsp0_valid, rsp1_valid  output  1  one-cycle pulse, read data returned to requester N.
REQ-008 rsp0_data, rsp1_data  output  8  read data, held until the next response to that port.
REQ-009 ram_din  output  10  command word to the single-port RAM.
REQ-010 ram_rx_valid  output  1  one-cycle strobe qualifying ram_din.
REQ-011 ram_dout  input  8  RAM read data.
REQ-012 ram_tx_valid  input  1  RAM read data valid.
REQ-013 grant_id  output  1  current/last owner; busy  output  1  lock held or read pending.
REQ-014 err  output  1  one-cycle pulse on any timeout.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOCKED, RD_WAIT.
REQ-016 IDLE, one valid: that port gets ready=1 combinationally in the same cycle.
REQ-017 IDLE, both valid: the port not last granted wins; the loser's ready stays 0.
REQ-018 Accepting a word SHALL drive ram_din=word and ram_rx_valid=1 on the next cycle.
REQ-019 An accepted 00 or 10 command SHALL move the FSM to LOCKED, owner=grant_id.
REQ-020 LOCKED: only the owner's ready may be 1; the other port is stalled.
REQ-021 LOCKED: an accepted 01 SHALL return the FSM to IDLE and release the lock.
REQ-022 LOCKED: an accepted 00 or 10 SHALL stay LOCKED; the new address supersedes the old.
REQ-023 An accepted 11, from IDLE or LOCKED, SHALL move the FSM to RD_WAIT.
REQ-024 RD_WAIT: all ready=0.
REQ-025 RD_WAIT: on ram_tx_valid, capture ram_dout into the owner's rsp_data and pulse rsp_valid the next cycle.
REQ-026 RD_WAIT: after the response, return to IDLE and release the lock.
REQ-027 A 01 accepted in IDLE is a single-word transaction: issued, no lock taken.
REQ-028 LOCKED: TIMEOUT consecutive cycles with owner valid=0 SHALL release the lock to IDLE and pulse err.
REQ-029 RD_WAIT: TIMEOUT cycles without ram_tx_valid SHALL pulse owner rsp_valid with data 8'h00, pulse err, and go to IDLE.
REQ-030 The timeout counter SHALL clear on every accepted word, response, and state change, and SHALL saturate, never wrap.
REQ-031 ram_tx_valid outside RD_WAIT SHALL be ignored.
REQ-032 busy=1 in LOCKED and RD_WAIT, else 0.
REQ-033 Latency: accepted word to ram_rx_valid is 1 cycle; ram_tx_valid to rsp_valid is 1 cycle.

Reset
REQ-034 rst_n low SHALL force IDLE and clear every output, response register, and the timeout counter.
REQ-035 Reset SHALL set last-granted to port 1, so port 0 wins the first tie.
REQ-036 Reset mid-transaction SHALL discard the lock and any pending read, with no rsp_valid emitted.

Structure
REQ-037 Shared package ram_arb_pkg SHALL hold:
- command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
- the FSM state encoding;
- TIMEOUT default.
REQ-038 The timeout counter SHALL be a sub-module arb_timeout_counter (clear, enable, expired).

Verification
REQ-039 Both valid at first cycle after reset, req0=10'h012, req1=10'h034 -> port 0 accepted, ram_din=10'h012 next cycle, FSM LOCKED, req1_ready=0.
REQ-040 Port 0 sends 10'h2A5 then 10'h300; RAM ram_tx_valid with 8'h5C 3 cycles later -> rsp0_valid pulse with rsp0_data=8'h5C, FSM IDLE; then port 1 (pending) granted.
REQ-041 Port 1 sends 10'h010 then 10'h1FF -> two ram_rx_valid strobes; lock released after 10'h1FF; next tie goes to port 0.
REQ-042 Port 0 locks with 10'h007, then valid=0 for 15 cycles -> err pulse, busy=0, port 1 granted in the following cycle.
REQ-043 Read issued, no ram_tx_valid for 15 cycles -> rsp_valid with data 8'h00 plus err pulse; late ram_tx_valid ignored.
REQ-044 rst_n asserted during RD_WAIT -> all outputs 0 immediately, no rsp_valid after release.
